// File: rtl/timers_acg_multi.sv
// timers_acg_multi: angle clock generator spreading 2^MULT_LOG2 ticks per tooth into a wrapping angle counter
module timers_acg_multi #(
   parameter int CNT_W     = 24,
   parameter int MULT_LOG2 = 3,
   parameter int ACR_W     = 24
) (
   input  logic             timers_acg_clock_i,
   input  logic             timers_acg_reset_i,
   input  logic             timers_acg_pdf_pht_i,
   input  logic [CNT_W-1:0] timers_sfr_tacp_i,
   input  logic             timers_sfr_tacp_we_i,
   input  logic [ACR_W-1:0] timers_sfr_acr_i,
   input  logic             timers_sfr_acr_we_i,
   input  logic             timers_sfr_tr2_i,
   input  logic             timers_sfr_tf2_clr_i,
   input  logic             timers_sfr_err_clr_i,
   output logic [ACR_W-1:0] timers_sfr_acr_o,
   output logic             timers_sfr_tf2_o,
   output logic [CNT_W-1:0] timers_acg_period_o,
   output logic             timers_acg_tick_o,
   output logic             timers_acg_stall_o,
   output logic             timers_acg_ovs_o
);
   localparam int N  = 1 << MULT_LOG2;
   localparam int KW = MULT_LOG2 + 1;
   typedef enum logic [2:0] {IDLE, MEAS, RUN, HOLD, CATCH, STALL} state_t;
   state_t state_q, state_d;
   logic [2:0] sync_q, sync_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d, per_q, per_d, t_q, t_d, ic_q, ic_d, p_meas;
   logic [KW-1:0] k_q, k_d, owed_q, owed_d, owed_new, owed_sat;
   logic [KW:0] catch_sum;
   logic [ACR_W-1:0] acr_q, acr_d;
   logic tick_q, tick_d, tf2_q, tf2_d, stall_q, stall_d, ovs_q, ovs_d;
   logic tooth, sat, tick, stall_trig, ovs_set, inc;
   function automatic logic [CNT_W-1:0] tval(input logic [CNT_W-1:0] p);
      tval = (p >> MULT_LOG2) == '0 ? CNT_W'(1) : p >> MULT_LOG2;
   endfunction
   assign tooth      = sync_q[1] & ~sync_q[2];
   assign sat        = &pcnt_q;
   assign p_meas     = sat ? pcnt_q : pcnt_q + CNT_W'(1);
   assign stall_trig = sat && state_q inside {MEAS, RUN, HOLD, CATCH};
   assign tick       = ((state_q == RUN && ic_q == t_q - CNT_W'(1)) || (state_q == CATCH && !tooth))
                       && !stall_trig && !timers_sfr_tacp_we_i;
   assign owed_new   = KW'(N) - k_q - KW'(tick);
   assign catch_sum  = {1'b0, owed_q} + (KW+1)'(N);
   assign owed_sat   = catch_sum > {1'b0, {KW{1'b1}}} ? '1 : catch_sum[KW-1:0];
   assign inc        = tick && timers_sfr_tr2_i;
   always_comb begin
      sync_d  = {sync_q[1:0], timers_acg_pdf_pht_i};
      state_d = state_q;
      pcnt_d  = tooth ? '0 : sat ? pcnt_q : pcnt_q + CNT_W'(1);
      per_d   = tooth ? p_meas : per_q;
      t_d     = tooth ? tval(p_meas) : t_q;
      ic_d    = ic_q;
      k_d     = k_q;
      owed_d  = owed_q;
      ovs_set = 1'b0;
      case (state_q)
         RUN: begin
            ic_d = tick ? '0 : ic_q + CNT_W'(1);
            k_d  = k_q + KW'(tick);
            if (tick && k_q == KW'(N - 1)) state_d = HOLD;
         end
         CATCH: begin
            ic_d   = '0;
            owed_d = owed_q - KW'(1);
            if (owed_q == KW'(1)) state_d = RUN;
         end
         default: ;
      endcase
      if (tooth) begin
         k_d  = '0;
         ic_d = '0;
         case (state_q)
            IDLE, STALL: begin
               state_d = MEAS;
               owed_d  = '0;
            end
            MEAS: state_d = RUN;
            RUN, HOLD: begin
               owed_d  = owed_new;
               state_d = owed_new != '0 ? CATCH : RUN;
            end
            default: begin
               owed_d  = owed_sat;
               ovs_set = 1'b1;
               state_d = CATCH;
            end
         endcase
      end
      if (stall_trig) begin
         state_d = STALL;
         owed_d  = '0;
         k_d     = '0;
         ic_d    = '0;
      end
      // a preload discards any same-cycle tooth, stall or overspeed event
      if (timers_sfr_tacp_we_i) begin
         state_d = RUN;
         per_d   = timers_sfr_tacp_i;
         t_d     = tval(timers_sfr_tacp_i);
         pcnt_d  = '0;
         ic_d    = '0;
         k_d     = '0;
         owed_d  = '0;
         ovs_set = 1'b0;
      end
      tick_d  = tick;
      acr_d   = timers_sfr_acr_we_i ? timers_sfr_acr_i : inc ? acr_q + ACR_W'(1) : acr_q;
      tf2_d   = (inc && &acr_q && !timers_sfr_acr_we_i) || (tf2_q && !timers_sfr_tf2_clr_i);
      stall_d = (stall_trig && !timers_sfr_tacp_we_i) || (stall_q && !timers_sfr_err_clr_i);
      ovs_d   = ovs_set || (ovs_q && !timers_sfr_err_clr_i);
   end
   always_ff @(posedge timers_acg_clock_i or posedge timers_acg_reset_i) begin
      if (timers_acg_reset_i) begin
         state_q <= IDLE;
         sync_q  <= '0;
         pcnt_q  <= '0;
         per_q   <= '0;
         t_q     <= CNT_W'(1);
         ic_q    <= '0;
         k_q     <= '0;
         owed_q  <= '0;
         tick_q  <= 1'b0;
         acr_q   <= '0;
         tf2_q   <= 1'b0;
         stall_q <= 1'b0;
         ovs_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         pcnt_q  <= pcnt_d;
         per_q   <= per_d;
         t_q     <= t_d;
         ic_q    <= ic_d;
         k_q     <= k_d;
         owed_q  <= owed_d;
         tick_q  <= tick_d;
         acr_q   <= acr_d;
         tf2_q   <= tf2_d;
         stall_q <= stall_d;
         ovs_q   <= ovs_d;
      end
   end
   assign timers_sfr_acr_o    = acr_q;
   assign timers_sfr_tf2_o    = tf2_q;
   assign timers_acg_period_o = per_q;
   assign timers_acg_tick_o   = tick_q;
   assign timers_acg_stall_o  = stall_q;
   assign timers_acg_ovs_o    = ovs_q;
endmodule

// File: tb/tb_timers_acg_multi.sv
// tb_timers_acg_multi: tick-time scoreboard plus flag/counter checks for timers_acg_multi
module tb_timers_acg_multi;
   logic clk = 1'b0, rst = 1'b1, pht = 1'b0;
   logic [7:0] tacp = '0, acr_in = '0;
   logic tacp_we = 1'b0, acr_we = 1'b0, tr2 = 1'b1, tf2_clr = 1'b0, err_clr = 1'b0;
   logic [7:0] acr, period;
   logic tf2, tick, stall, ovs;
   int cyc = 0, n_chk = 0, n_err = 0;
   int exp_q[$];
   timers_acg_multi #(.CNT_W(8), .MULT_LOG2(3), .ACR_W(8)) dut (
      .timers_acg_clock_i(clk), .timers_acg_reset_i(rst), .timers_acg_pdf_pht_i(pht),
      .timers_sfr_tacp_i(tacp), .timers_sfr_tacp_we_i(tacp_we),
      .timers_sfr_acr_i(acr_in), .timers_sfr_acr_we_i(acr_we),
      .timers_sfr_tr2_i(tr2), .timers_sfr_tf2_clr_i(tf2_clr), .timers_sfr_err_clr_i(err_clr),
      .timers_sfr_acr_o(acr), .timers_sfr_tf2_o(tf2), .timers_acg_period_o(period),
      .timers_acg_tick_o(tick), .timers_acg_stall_o(stall), .timers_acg_ovs_o(ovs));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask
   always @(negedge clk)
      if (tick) begin
         if (exp_q.size() == 0) chk("tick_extra", cyc, 0);
         else chk("tick_time", cyc, exp_q.pop_front());
      end
   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask
   task automatic pulse_at(input int c);
      wait_until(c);
      pht = 1'b1;
      wait_until(c + 2);
      pht = 1'b0;
   endtask
   task automatic push_run(input int e, input int t, input int n);
      for (int j = 1; j <= n; j++) exp_q.push_back(e + t * j);
   endtask
   task automatic preload(input int c, input logic [7:0] v);
      wait_until(c);
      tacp = v;
      tacp_we = 1'b1;
      wait_until(c + 1);
      tacp_we = 1'b0;
   endtask
   initial begin
      wait_until(3);
      rst = 1'b0;
      chk("rst_acr", acr, 0);
      chk("rst_tf2", tf2, 0);
      chk("rst_period", period, 0);
      chk("rst_tick", tick, 0);
      chk("rst_stall", stall, 0);
      chk("rst_ovs", ovs, 0);
      // steady teeth every 80, then acceleration to 60
      pulse_at(10);
      pulse_at(90);
      push_run(93, 10, 8);
      pulse_at(170);
      push_run(173, 10, 6);
      wait_until(200);
      chk("steady_period", period, 80);
      pulse_at(230);
      exp_q.push_back(234);
      exp_q.push_back(235);
      push_run(235, 7, 8);
      wait_until(300);
      chk("accel_period", period, 60);
      chk("accel_acr", acr, 24);
      wait_until(480);
      chk("stall_early", stall, 0);
      wait_until(495);
      chk("stall_set", stall, 1);
      // stall recovery, deceleration 80 -> 120
      pulse_at(500);
      wait_until(540);
      chk("stall_sticky", stall, 1);
      wait_until(545);
      err_clr = 1'b1;
      wait_until(546);
      err_clr = 1'b0;
      wait_until(547);
      chk("stall_clr", stall, 0);
      pulse_at(580);
      push_run(583, 10, 8);
      pulse_at(700);
      wait_until(710);
      chk("decel_period", period, 120);
      exp_q.push_back(718);
      wait_until(715);
      chk("ovs_before", ovs, 0);
      // teeth crowding into CATCH: owed 7, then 13, then saturated at 15
      pulse_at(715);
      exp_q.push_back(719);
      exp_q.push_back(720);
      pulse_at(718);
      exp_q.push_back(722);
      exp_q.push_back(723);
      pulse_at(721);
      push_run(724, 1, 23);
      wait_until(760);
      chk("ovs_set", ovs, 1);
      chk("ovs_acr", acr, 60);
      wait_until(762);
      err_clr = 1'b1;
      wait_until(763);
      err_clr = 1'b0;
      wait_until(764);
      chk("ovs_clr", ovs, 0);
      // software preload
      preload(800, 8'd40);
      push_run(801, 5, 8);
      wait_until(850);
      chk("pre_period", period, 40);
      chk("pre_acr", acr, 68);
      // ACR load, wrap, clear/set race, tr2 gating, load priority
      wait_until(900);
      acr_in = 8'hff;
      acr_we = 1'b1;
      tacp_we = 1'b1;
      wait_until(901);
      acr_we = 1'b0;
      tacp_we = 1'b0;
      push_run(901, 5, 8);
      wait_until(903);
      chk("load_acr", acr, 255);
      wait_until(906);
      chk("wrap_acr", acr, 0);
      chk("wrap_tf2", tf2, 1);
      acr_we = 1'b1;
      wait_until(907);
      acr_we = 1'b0;
      wait_until(910);
      tf2_clr = 1'b1;
      wait_until(911);
      tf2_clr = 1'b0;
      chk("wrap2_acr", acr, 0);
      chk("wrap2_tf2", tf2, 1);
      wait_until(912);
      tf2_clr = 1'b1;
      wait_until(913);
      tf2_clr = 1'b0;
      chk("tf2_clr", tf2, 0);
      tr2 = 1'b0;
      wait_until(917);
      chk("tr2_off_acr", acr, 0);
      tr2 = 1'b1;
      wait_until(925);
      acr_in = 8'd100;
      acr_we = 1'b1;
      wait_until(926);
      acr_we = 1'b0;
      chk("load_prio", acr, 100);
      wait_until(950);
      chk("acr_final", acr, 103);
      // reset in the middle of CATCH
      preload(1000, 8'd40);
      pulse_at(1004);
      exp_q.push_back(1006);
      exp_q.push_back(1008);
      wait_until(1008);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_acr", acr, 0);
      chk("mid_rst_tf2", tf2, 0);
      chk("mid_rst_period", period, 0);
      chk("mid_rst_tick", tick, 0);
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_ovs", ovs, 0);
      wait_until(1012);
      rst = 1'b0;
      wait_until(1040);
      chk("post_rst_acr", acr, 0);
      chk("ticks_left", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
